// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the radix-4 Booth partial-product accumulator.
package booth_pkg;
  localparam int N      = 32;
  localparam int NUM_PP = N / 2;
  localparam int PP_W   = N + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/pp_shift_ext.sv
// Combinational sign-extension of one Booth partial product to 2N bits, weighted by 4^idx.
module pp_shift_ext
  import booth_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic [N+1:0]   pp,
  input  logic [IDX_W-1:0] idx,
  output logic [2*N-1:0] term
);
  logic [2*N-1:0] ext;

  assign ext  = {{(N-2){pp[N+1]}}, pp};
  assign term = ext << {idx, 1'b0};
endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates NUM_PP radix-4 Booth partial products into a signed 2N-bit product.
// Optional macro BOOTH_ACC_PIPE_EN registers the extended term before the adder.
module booth_pp_accumulator #(
  parameter int N      = booth_pkg::N,
  parameter int NUM_PP = N / 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           pp_valid,
  input  logic [N+1:0]   pp_in,
  output logic           pp_ready,
  output logic [2*N-1:0] out,
  output logic           done,
  output logic           busy
);
  import booth_pkg::*;

  localparam int IDX_W = $clog2(NUM_PP) + 1;

  state_t           state;
  logic [2*N-1:0]   acc;
  logic [IDX_W-1:0] pp_idx;
  logic [2*N-1:0]   term;
  logic             accept;
  logic             last;

  pp_shift_ext #(.N(N), .IDX_W(IDX_W)) u_shift (
    .pp   (pp_in),
    .idx  (pp_idx),
    .term (term)
  );

  assign accept = pp_valid && pp_ready;
  assign last   = (pp_idx == IDX_W'(NUM_PP - 1));

`ifdef BOOTH_ACC_PIPE_EN
  logic [2*N-1:0] term_q;
  logic           term_vld;
  logic           drain;

  // Once the final term is captured, intake closes until it reaches acc.
  assign pp_ready = (state == ACCUM) && !drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      pp_idx   <= '0;
      out      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      term_q   <= '0;
      term_vld <= 1'b0;
      drain    <= 1'b0;
    end else begin
      done     <= 1'b0;
      term_vld <= 1'b0;
      if (term_vld) acc <= acc + term_q;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= ACCUM;
            acc    <= '0;
            pp_idx <= '0;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        ACCUM: begin
          if (accept) begin
            term_q   <= term;
            term_vld <= 1'b1;
            pp_idx   <= pp_idx + 1'b1;
            if (last) drain <= 1'b1;
          end
          if (drain && term_vld) begin
            out   <= acc + term_q;
            done  <= 1'b1;
            busy  <= 1'b0;
            drain <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic [2*N-1:0] acc_next;

  assign pp_ready = (state == ACCUM);
  assign acc_next = acc + term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      pp_idx <= '0;
      out    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= ACCUM;
            acc    <= '0;
            pp_idx <= '0;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc    <= acc_next;
            pp_idx <= pp_idx + 1'b1;
            if (last) begin
              out   <= acc_next;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench: Booth digits derived from random multipliers, expected product = md*mr.
module tb_booth_pp_accumulator;
  localparam int N = 32;
  localparam int NPP = 16;
`ifdef BOOTH_ACC_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          pp_valid;
  logic [N+1:0]  pp_in;
  logic          pp_ready;
  logic [2*N-1:0] out;
  logic          done;
  logic          busy;

  int tests = 0;
  int fails = 0;
  logic [2*N-1:0] exp_q[$];
  logic done_prev = 1'b0;

  booth_pp_accumulator #(.N(N), .NUM_PP(NPP)) dut (
    .clk(clk), .reset(reset), .start(start), .pp_valid(pp_valid), .pp_in(pp_in),
    .pp_ready(pp_ready), .out(out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (done_prev) begin
        tests++; fails++;
        $display("FAIL done_width: done high on consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: out=%h with nothing expected", out);
      end else begin
        check("product", out, exp_q.pop_front());
      end
    end
    done_prev = done;
  end

  // Reference: radix-4 Booth digit i of mr times md, as an N+2 bit two's-complement value.
  function automatic logic [N+1:0] booth_pp(input logic [31:0] md, input logic [31:0] mr, input int i);
    logic [32:0] m2;
    longint d;
    longint p;
    m2 = {mr, 1'b0};
    d = -2 * longint'(m2[2*i+2]) + longint'(m2[2*i+1]) + longint'(m2[2*i]);
    p = d * longint'($signed(md));
    return p[N+1:0];
  endfunction

  // mode 0: valid every cycle, 1: toggled 1/0, 2: random valid plus stray starts.
  task automatic do_frame(input logic [N+1:0] pps[NPP], input logic [63:0] expv,
                          input int mode, input bit issue_start, input bit hold_start);
    int i;
    int cyc;
    int lat;
    bit v;
    if (issue_start) begin
      @(negedge clk); start = 1'b1; pp_valid = 1'b0;
      @(negedge clk); start = 1'b0;
    end else begin
      @(negedge clk); start = 1'b0;
      check("b2b_no_idle_ready", {63'd0, pp_ready}, 64'd1);
    end
    exp_q.push_back(expv);
    i = 0; cyc = 0;
    while (i < NPP && cyc < 400) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 1) == 1;
      endcase
      pp_valid = v;
      pp_in = v ? pps[i] : (N+2)'($urandom);
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      if (v && pp_ready) i++;
      @(negedge clk);
      cyc++;
    end
    lat = 1;
    start = hold_start;
    pp_valid = $urandom_range(0, 1) == 1;
    pp_in = (N+2)'($urandom);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("latency", 64'(lat), 64'(EXP_LAT));
    end
  endtask

  logic [N+1:0] pps[NPP];
  logic [31:0] md, mr;
  logic signed [63:0] a, b;

  initial begin
    reset = 1'b1; start = 1'b0; pp_valid = 1'b0; pp_in = '0;
    repeat (2) @(negedge clk);
    check("reset_out", out, 64'd0);
    check("reset_flags", {60'd0, done, busy, pp_ready, 1'b0}, 64'd0);
    reset = 1'b0;

    // md=3, mr=5
    for (int k = 0; k < NPP; k++) pps[k] = '0;
    pps[0] = 34'd3; pps[1] = 34'd3;
    do_frame(pps, 64'd15, 0, 1'b1, 1'b0);
    // md=-1, mr=1
    for (int k = 0; k < NPP; k++) pps[k] = '0;
    pps[0] = 34'h3_FFFF_FFFF;
    do_frame(pps, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b0);
    // md=mr=0x8000_0000
    for (int k = 0; k < NPP; k++) pps[k] = '0;
    pps[15] = 34'h1_0000_0000;
    do_frame(pps, 64'h4000_0000_0000_0000, 0, 1'b1, 1'b0);
    // Stalled 3*5
    for (int k = 0; k < NPP; k++) pps[k] = '0;
    pps[0] = 34'd3; pps[1] = 34'd3;
    do_frame(pps, 64'd15, 1, 1'b1, 1'b0);
    check("out_held", out, 64'd15);

    // Reset after 7 accepts abandons the frame.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      pp_valid = 1'b1; pp_in = pps[k];
      @(negedge clk);
    end
    pp_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_out", out, 64'd0);
    check("midreset_flags", {61'd0, done, busy, pp_ready}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_frame(pps, 64'd15, 0, 1'b1, 1'b0);

    // Back-to-back frames: start held through the DONE cycle.
    do_frame(pps, 64'd15, 0, 1'b1, 1'b1);
    md = 32'h8000_0000; mr = 32'h7FFF_FFFF;
    for (int k = 0; k < NPP; k++) pps[k] = booth_pp(md, mr, k);
    a = $signed(md); b = $signed(mr);
    do_frame(pps, a * b, 2, 1'b0, 1'b0);

    // Random operands across all valid patterns, some back-to-back.
    for (int f = 0; f < 24; f++) begin
      bit b2b_next;
      md = $urandom; mr = $urandom;
      if (f % 8 == 0) md = 32'hFFFF_FFFF;
      for (int k = 0; k < NPP; k++) pps[k] = booth_pp(md, mr, k);
      a = $signed(md); b = $signed(mr);
      b2b_next = (f % 3 == 1);
      do_frame(pps, a * b, f % 3, !(f % 3 == 2), b2b_next);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
